// File: rtl/animated_color_pwm.sv
`timescale 1ns/1ps
// Six-phase RGB hue-wheel animator, advanced on rising edges of tick_in, driving three 8-bit PWM outputs.
// Levels update 2 clk after a tick_in rise; PWM picks new levels up at the next period start.
module animated_color_pwm #(
  parameter int PWM_PRESCALE = 4,
  parameter int STEP         = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       enable,
  output logic       red_pwm,
  output logic       green_pwm,
  output logic       blue_pwm,
  output logic [7:0] red_lvl,
  output logic [7:0] green_lvl,
  output logic [7:0] blue_lvl,
  output logic [2:0] phase,
  output logic       wrap
);

  typedef enum logic [2:0] {
    RISE_G = 3'd0,
    FALL_R = 3'd1,
    RISE_B = 3'd2,
    FALL_G = 3'd3,
    RISE_R = 3'd4,
    FALL_B = 3'd5
  } phase_t;

  localparam int         PS_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);

  logic   tickQ, tickD, stepEvt;
  phase_t phaseQ;
  logic   rising, atTerm;
  logic [7:0] curLvl, nextLvl;
  logic [8:0] sum9, diff9;

  logic [PS_W-1:0] preCnt;
  logic            preWrap;
  logic [7:0]      pwmCnt;
  logic [7:0]      shadowR, shadowG, shadowB;

  // Reset high so a tick_in already high at release is not taken as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tickQ <= 1'b1;
      tickD <= 1'b1;
    end else begin
      tickQ <= tick_in;
      tickD <= tickQ;
    end
  end

  assign stepEvt = tickQ & ~tickD & enable;

  always_comb begin
    curLvl = red_lvl;
    rising = 1'b0;
    case (phaseQ)
      RISE_G: begin curLvl = green_lvl; rising = 1'b1; end
      FALL_R: begin curLvl = red_lvl;   rising = 1'b0; end
      RISE_B: begin curLvl = blue_lvl;  rising = 1'b1; end
      FALL_G: begin curLvl = green_lvl; rising = 1'b0; end
      RISE_R: begin curLvl = red_lvl;   rising = 1'b1; end
      FALL_B: begin curLvl = blue_lvl;  rising = 1'b0; end
      default: begin curLvl = red_lvl;  rising = 1'b0; end
    endcase
    sum9  = {1'b0, curLvl} + STEP9;
    diff9 = {1'b0, curLvl} - STEP9;
    // Saturate rather than wrap; a borrow out of the subtract means below zero.
    if (rising) nextLvl = (sum9 > 9'd255) ? 8'hFF : sum9[7:0];
    else        nextLvl = diff9[8] ? 8'h00 : diff9[7:0];
    atTerm = rising ? (nextLvl == 8'hFF) : (nextLvl == 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_lvl   <= 8'hFF;
      green_lvl <= 8'h00;
      blue_lvl  <= 8'h00;
      phaseQ    <= RISE_G;
      wrap      <= 1'b0;
    end else if (phaseQ > FALL_B) begin
      red_lvl   <= 8'hFF;
      green_lvl <= 8'h00;
      blue_lvl  <= 8'h00;
      phaseQ    <= RISE_G;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stepEvt) begin
        case (phaseQ)
          RISE_G, FALL_G: green_lvl <= nextLvl;
          FALL_R, RISE_R: red_lvl   <= nextLvl;
          default:        blue_lvl  <= nextLvl;
        endcase
        if (atTerm) begin
          if (phaseQ == FALL_B) begin
            phaseQ <= RISE_G;
            wrap   <= 1'b1;
          end else begin
            phaseQ <= phase_t'(phaseQ + 3'd1);
          end
        end
      end
    end
  end

  assign phase   = phaseQ;
  assign preWrap = (preCnt == PS_LAST);

  // Shadows load only at the 255->0 rollover so one period never mixes levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      preCnt    <= '0;
      pwmCnt    <= 8'h00;
      shadowR   <= 8'hFF;
      shadowG   <= 8'h00;
      shadowB   <= 8'h00;
      red_pwm   <= 1'b0;
      green_pwm <= 1'b0;
      blue_pwm  <= 1'b0;
    end else begin
      preCnt <= preWrap ? '0 : preCnt + 1'b1;
      if (preWrap) begin
        pwmCnt <= pwmCnt + 8'd1;
        if (pwmCnt == 8'hFF) begin
          shadowR <= red_lvl;
          shadowG <= green_lvl;
          shadowB <= blue_lvl;
        end
      end
      red_pwm   <= (pwmCnt < shadowR);
      green_pwm <= (pwmCnt < shadowG);
      blue_pwm  <= (pwmCnt < shadowB);
    end
  end

endmodule

// File: tb/tb_animated_color_pwm.sv
`timescale 1ns/1ps
// Directed bench for animated_color_pwm: reset, stepping, phase boundaries, wrap, enable gating, async reset.
module tb_animated_color_pwm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_in = 1'b1;
  logic       enable = 1'b1;
  logic       red_pwm, green_pwm, blue_pwm;
  logic [7:0] red_lvl, green_lvl, blue_lvl;
  logic [2:0] phase;
  logic       wrap;

  int errors = 0;
  int checks = 0;
  int wrapCnt = 0;

  animated_color_pwm #(.PWM_PRESCALE(4), .STEP(5)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .enable(enable),
    .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm),
    .red_lvl(red_lvl), .green_lvl(green_lvl), .blue_lvl(blue_lvl),
    .phase(phase), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap === 1'b1) wrapCnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      waitClk(2);
      tick_in = 1'b0;
      waitClk(2);
    end
  endtask

  task automatic countHigh(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r += int'(red_pwm);
      g += int'(green_pwm);
      b += int'(blue_pwm);
    end
  endtask

  task automatic checkLvls(input string tag, input int r, input int g, input int b, input int p);
    check({tag, "_red"},   32'(red_lvl),   32'(r));
    check({tag, "_green"}, 32'(green_lvl), 32'(g));
    check({tag, "_blue"},  32'(blue_lvl),  32'(b));
    check({tag, "_phase"}, 32'(phase),     32'(p));
  endtask

  initial begin
    int changes;
    int rc, gc, bc;

    // Reset held with tick_in high
    waitClk(3);
    checkLvls("reset", 255, 0, 0, 0);
    check("reset_wrap", 32'(wrap), 0);
    check("reset_rpwm", 32'(red_pwm), 0);
    check("reset_gpwm", 32'(green_pwm), 0);
    check("reset_bpwm", 32'(blue_pwm), 0);

    // Release with tick_in still high: no event, idle duty
    reset_n = 1'b1;
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (red_lvl !== 8'd255 || green_lvl !== 8'd0 || blue_lvl !== 8'd0 || phase !== 3'd0)
        changes++;
    end
    check("idle_no_change", 32'(changes), 0);
    countHigh(1024, rc, gc, bc);
    check("idle_red_duty", 32'(rc), 1020);
    check("idle_green_duty", 32'(gc), 0);
    check("idle_blue_duty", 32'(bc), 0);

    // Single step: 2 clk latency
    tick_in = 1'b0;
    waitClk(2);
    tick_in = 1'b1;
    waitClk(1);
    check("step_lat1_green", 32'(green_lvl), 0);
    waitClk(1);
    check("step_lat2_green", 32'(green_lvl), 5);
    check("step_lat2_phase", 32'(phase), 0);
    tick_in = 1'b0;
    waitClk(2);
    waitClk(1100);
    countHigh(1024, rc, gc, bc);
    check("step_green_duty", 32'(gc), 20);
    check("step_red_duty", 32'(rc), 1020);
    check("step_blue_duty", 32'(bc), 0);

    // Phase boundary at the 51st event
    pulses(49);
    checkLvls("ev50", 255, 250, 0, 0);
    tick_in = 1'b1;
    waitClk(1);
    check("ev51_pre_phase", 32'(phase), 0);
    waitClk(1);
    check("ev51_green", 32'(green_lvl), 255);
    check("ev51_phase", 32'(phase), 1);
    tick_in = 1'b0;
    waitClk(2);
    pulses(1);
    checkLvls("ev52", 250, 255, 0, 1);

    pulses(50);
    checkLvls("ev102", 0, 255, 0, 2);
    pulses(51);
    checkLvls("ev153", 0, 255, 255, 3);
    pulses(152);
    checkLvls("ev305", 255, 0, 5, 5);
    check("ev305_no_wrap", 32'(wrapCnt), 0);

    // 306th event closes the revolution
    tick_in = 1'b1;
    waitClk(1);
    check("ev306_pre_wrap", 32'(wrap), 0);
    waitClk(1);
    check("ev306_wrap", 32'(wrap), 1);
    checkLvls("ev306", 255, 0, 0, 0);
    waitClk(1);
    check("ev306_wrap_drop", 32'(wrap), 0);
    tick_in = 1'b0;
    waitClk(2);
    check("wrap_count", 32'(wrapCnt), 1);

    // Enable gating
    enable = 1'b0;
    pulses(10);
    checkLvls("disabled", 255, 0, 0, 0);
    tick_in = 1'b1;
    waitClk(3);
    enable = 1'b1;
    waitClk(3);
    check("reenable_high_green", 32'(green_lvl), 0);
    tick_in = 1'b0;
    waitClk(2);
    pulses(1);
    check("reenable_step_green", 32'(green_lvl), 5);

    // Async reset mid-phase
    pulses(183);
    checkLvls("ev184", 0, 100, 255, 3);
    #1 reset_n = 1'b0;
    #1;
    checkLvls("async_rst", 255, 0, 0, 0);
    check("async_rst_wrap", 32'(wrap), 0);
    check("async_rst_gpwm", 32'(green_pwm), 0);
    check("async_rst_bpwm", 32'(blue_pwm), 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitClk(2);
    pulses(1);
    checkLvls("post_rst_step", 255, 5, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
